// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory.
//
// Aligned stores from the MEM stage are queued in a DEPTH-entry FIFO and
// drained to data memory one per cycle whenever memory is ready. Loads are
// never forwarded from the buffer: a load holds the pipeline until the
// buffer has fully drained.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   memwrite   store request: 00 none, 01 word, 10 halfword, 11 byte
//   dataadr    byte address of the MEM-stage access
//   writedata  store data, right-aligned
//   memread    load in MEM stage
//   mem_ready  data memory accepts the presented write this cycle
//   stall      pipeline hold request (combinational)
//   misalign   one-cycle pulse after a rejected misaligned store
//   mem_we     head entry valid toward data memory
//   mem_adr    word address of the head entry (zero when empty)
//   mem_wdata  lane-replicated data of the head entry (zero when empty)
//   mem_be     byte enables of the head entry (zero when empty)
//   empty      no entries held
//   count      number of entries held
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic                     memread,
  input  logic                     mem_ready,
  output logic                     stall,
  output logic                     misalign,
  output logic                     mem_we,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Per-entry storage; contents are don't-care outside [rd_ptr, wr_ptr).
  logic [29:0] adr_mem   [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  be_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q, misalign_d;

  logic          is_store;
  logic          aligned;
  logic [3:0]    store_be;
  logic [31:0]   store_wdata;
  logic          full;
  logic          push;
  logic          pop;

  // Decode the MEM-stage store into lane enables and replicated data.
  always_comb begin
    is_store    = 1'b0;
    aligned     = 1'b1;
    store_be    = 4'b0000;
    store_wdata = 32'h0;
    unique case (memwrite)
      2'b01: begin
        is_store    = 1'b1;
        aligned     = (dataadr[1:0] == 2'b00);
        store_be    = 4'b1111;
        store_wdata = writedata;
      end
      2'b10: begin
        is_store    = 1'b1;
        aligned     = ~dataadr[0];
        store_be    = dataadr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{writedata[15:0]}};
      end
      2'b11: begin
        is_store    = 1'b1;
        aligned     = 1'b1;
        store_be    = 4'b0001 << dataadr[1:0];
        store_wdata = {4{writedata[7:0]}};
      end
      default: begin
        is_store    = 1'b0;
      end
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Fullness is judged at the start of the cycle, so a pop never frees a
  // slot for a push in the same cycle.
  assign push = is_store & aligned & ~full;
  assign pop  = ~empty & mem_ready;

  assign stall = (is_store & aligned & full) | (memread & ~empty);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = is_store & ~aligned;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      adr_mem[wr_ptr_q]   <= dataadr[31:2];
      wdata_mem[wr_ptr_q] <= store_wdata;
      be_mem[wr_ptr_q]    <= store_be;
    end
  end

  always_comb begin
    mem_we    = ~empty;
    mem_adr   = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (!empty) begin
      mem_adr   = {adr_mem[rd_ptr_q], 2'b00};
      mem_wdata = wdata_mem[rd_ptr_q];
      mem_be    = be_mem[rd_ptr_q];
    end
  end

  assign misalign = misalign_q;
  assign count    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        memread;
  logic        mem_ready;
  logic        stall;
  logic        misalign;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .memread   (memread),
    .mem_ready (mem_ready),
    .stall     (stall),
    .misalign  (misalign),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .empty     (empty),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output snapshot layout:
  // [74] stall [73] misalign [72] mem_we [71:40] mem_adr [39:8] mem_wdata
  // [7:4] mem_be [3] empty [2:0] count
  typedef logic [74:0] snap_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  be;
  } entry_t;

  typedef struct {
    logic        rst;
    logic [1:0]  mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rd;
    logic        rdy;
    snap_t       exp;
  } vec_t;

  entry_t q[$];
  logic   mis_m;
  int     n_cmp  = 0;
  int     n_fail = 0;

  function automatic snap_t pack(logic st, logic mis, logic we, logic [31:0] adr,
                                 logic [31:0] wd, logic [3:0] be, logic emp, logic [2:0] cnt);
    return {st, mis, we, adr, wd, be, emp, cnt};
  endfunction

  function automatic snap_t dut_out();
    return {stall, misalign, mem_we, mem_adr, mem_wdata, mem_be, empty, count};
  endfunction

  function automatic logic aligned_f(logic [1:0] mw, logic [31:0] adr);
    if (mw == 2'b01) return adr[1:0] == 2'b00;
    if (mw == 2'b10) return adr[0] == 1'b0;
    return 1'b1;
  endfunction

  // Reference model: a plain queue of pending memory writes.
  function automatic snap_t model_out();
    logic st;
    st = (memwrite != 2'b00 && aligned_f(memwrite, dataadr) && q.size() == DEPTH) ||
         (memread && q.size() != 0);
    if (q.size() == 0) return pack(st, mis_m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 3'd0);
    return pack(st, mis_m, 1'b1, q[0].adr, q[0].wd, q[0].be, 1'b0, 3'(q.size()));
  endfunction

  task automatic model_update();
    entry_t e;
    logic   can_push;
    if (reset) begin
      q.delete();
      mis_m = 1'b0;
      return;
    end
    can_push = memwrite != 2'b00 && aligned_f(memwrite, dataadr) && q.size() < DEPTH;
    if (q.size() != 0 && mem_ready) void'(q.pop_front());
    if (can_push) begin
      e.adr = {dataadr[31:2], 2'b00};
      case (memwrite)
        2'b01:   begin e.be = 4'b1111; e.wd = writedata; end
        2'b10:   begin
          e.be = dataadr[1] ? 4'b1100 : 4'b0011;
          e.wd = writedata[15:0] * 32'h0001_0001;
        end
        default: begin
          e.be = 4'(1 << dataadr[1:0]);
          e.wd = writedata[7:0] * 32'h0101_0101;
        end
      endcase
      q.push_back(e);
    end
    mis_m = memwrite != 2'b00 && !aligned_f(memwrite, dataadr);
  endtask

  task automatic check(input string name, input snap_t act, input snap_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] mw, input logic [31:0] adr,
                      input logic [31:0] wd, input logic rd, input logic rdy,
                      input string name, output snap_t act);
    reset     = rst;
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    memread   = rd;
    mem_ready = rdy;
    @(negedge clk);
    act = dut_out();
    check({name, "_model"}, act, model_out());
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t  vecs[14];
  snap_t act;
  snap_t z;

  initial begin
    z = pack(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 3'd0);
    vecs[0]  = '{0, 2'b00, 32'h0,   32'h0,      0, 1, z};
    vecs[1]  = '{0, 2'b11, 32'h51,  32'hFF,     0, 1, z};
    vecs[2]  = '{0, 2'b00, 32'h0,   32'h0,      0, 1,
                 pack(0, 0, 1, 32'h50, 32'hFFFF_FFFF, 4'b0010, 0, 3'd1)};
    vecs[3]  = '{0, 2'b10, 32'h52,  32'hAAFF,   0, 1, z};
    vecs[4]  = '{0, 2'b00, 32'h0,   32'h0,      0, 1,
                 pack(0, 0, 1, 32'h50, 32'hAAFF_AAFF, 4'b1100, 0, 3'd1)};
    vecs[5]  = '{0, 2'b01, 32'h52,  32'h1111,   0, 1, z};
    vecs[6]  = '{0, 2'b00, 32'h0,   32'h0,      0, 1,
                 pack(0, 1, 0, 32'h0, 32'h0, 4'h0, 1, 3'd0)};
    vecs[7]  = '{0, 2'b00, 32'h0,   32'h0,      0, 1, z};
    vecs[8]  = '{0, 2'b01, 32'h100, 32'h1234_5678, 0, 0, z};
    vecs[9]  = '{0, 2'b11, 32'h103, 32'hAB,     0, 0,
                 pack(0, 0, 1, 32'h100, 32'h1234_5678, 4'b1111, 0, 3'd1)};
    vecs[10] = '{0, 2'b00, 32'h0,   32'h0,      1, 0,
                 pack(1, 0, 1, 32'h100, 32'h1234_5678, 4'b1111, 0, 3'd2)};
    vecs[11] = '{0, 2'b00, 32'h0,   32'h0,      1, 1,
                 pack(1, 0, 1, 32'h100, 32'h1234_5678, 4'b1111, 0, 3'd2)};
    vecs[12] = '{0, 2'b00, 32'h0,   32'h0,      1, 1,
                 pack(1, 0, 1, 32'h100, 32'hABAB_ABAB, 4'b1000, 0, 3'd1)};
    vecs[13] = '{0, 2'b00, 32'h0,   32'h0,      1, 0, z};

    // Initial reset; DUT state is unknown before it, so nothing is compared.
    reset = 1'b1; memwrite = 2'b00; dataadr = '0; writedata = '0;
    memread = 1'b0; mem_ready = 1'b0;
    q.delete();
    mis_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].rdy,
           $sformatf("vec%0d", i), act);
      check($sformatf("vec%0d_table", i), act, vecs[i].exp);
    end

    // Fill to full with memory blocked, then release it for one cycle.
    for (int i = 0; i < 4; i++)
      step(0, 2'b01, 32'(i * 4), 32'(i + 32'hA0), 0, 0, "fill", act);
    step(0, 2'b01, 32'h10, 32'hA4, 0, 0, "fill_full", act);
    check("fill_count", 75'(act[2:0]), 75'(4));
    check("fill_stall", 75'(act[74]), 75'(1));
    step(0, 2'b01, 32'h10, 32'hA4, 0, 1, "fill_pop", act);
    check("fill_pop_stall", 75'(act[74]), 75'(1));
    check("fill_pop_head", 75'(act[71:40]), 75'(0));
    step(0, 2'b01, 32'h10, 32'hA4, 0, 0, "fill_accept", act);
    check("fill_accept_stall", 75'(act[74]), 75'(0));
    check("fill_accept_count", 75'(act[2:0]), 75'(3));
    for (int k = 0; k < 4; k++) begin
      step(0, 2'b00, 32'h0, 32'h0, 0, 1, "drain", act);
      check($sformatf("drain%0d_adr", k), 75'(act[71:40]), 75'(32'(4 * (k + 1))));
      check($sformatf("drain%0d_data", k), 75'(act[39:8]), 75'(32'hA1 + 32'(k)));
    end
    step(0, 2'b00, 32'h0, 32'h0, 0, 1, "drained", act);
    check("drained_empty", 75'(act[3]), 75'(1));

    // Reset with three entries pending and a store presented during reset.
    for (int i = 0; i < 3; i++)
      step(0, 2'b01, 32'h300 + 32'(i * 4), 32'(i), 0, 0, "preload", act);
    check("preload_count", 75'(act[2:0]), 75'(2));
    step(1, 2'b01, 32'h400, 32'h55, 0, 0, "midreset", act);
    check("midreset_count_before", 75'(act[2:0]), 75'(3));
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 32'h0, 32'h0, 0, 1, "postreset", act);
      check($sformatf("postreset%0d", i), act, z);
    end

    // Randomised traffic checked against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  mw;
      logic        rd;
      logic        rdy;
      mw  = 2'($urandom_range(0, 3));
      rd  = (mw == 2'b00) && ($urandom_range(0, 3) == 0);
      rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 80) == 0, mw, $urandom, $urandom, rd, rdy,
           $sformatf("rand%0d", i), act);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 memwrite  input  2  store request from MEM stage: 00 none, 01 word (sw), 10 halfword (sh), 11 byte (sb).
REQ-005 dataadr  input  32  store/load byte address from MEM stage.
REQ-006 writedata  input  32  store data; significant bits right-aligned (byte in [7:0], half in [15:0]).
REQ-007 memread  input  1  load in MEM stage this cycle.
REQ-008 mem_ready  input  1  data memory accepts the presented write this cycle.
REQ-009 stall  output  1  pipeline hold request, combinational.
REQ-010 misalign  output  1  registered one-cycle pulse flagging a rejected misaligned store.
REQ-011 mem_we  output  1  write valid toward data memory.
REQ-012 mem_adr  output  32  word address of the head entry: {addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  lane-replicated write data of the head entry.
REQ-014 mem_be  output  4  byte enables of the head entry; bit k enables bits [8k+7:8k].
REQ-015 empty  output  1  no entries held.
REQ-016 count  output  $clog2(DEPTH)+1  number of entries held.

Function
REQ-017 Lane mapping is little-endian: byte address offset k=addr[1:0] selects lane k.
REQ-018 Byte store: be = 1<<addr[1:0]; wdata = writedata[7:0] replicated to all four lanes.
REQ-019 Halfword store: be = 0011 if addr[1]=0, else 1100; wdata = writedata[15:0] replicated to both halves.
REQ-020 Word store: be = 1111; wdata = writedata.
REQ-021 Misaligned store (half with addr[0]=1; word with addr[1:0]!=00) is not enqueued, does not stall, and sets misalign high for exactly the following cycle.
REQ-022 Full means count==DEPTH; an aligned store is accepted at the rising edge only if not full at the start of that cycle.
REQ-023 Pop occurs at the rising edge when mem_we=1 and mem_ready=1; the popped slot is not reusable by a push in the same cycle when full.
REQ-024 Simultaneous push and pop with count<DEPTH: count unchanged, both pointers advance.
REQ-025 Read and write pointers wrap modulo DEPTH; FIFO order is preserved across wrap.
REQ-026 Latency: a store accepted at edge N appears on mem_* during cycle N+1 if it is the head entry; minimum store-to-memory latency 1 cycle.
REQ-027 mem_we = !empty; when empty, mem_adr, mem_wdata, mem_be are driven to zero.
REQ-028 Head outputs remain stable while mem_we=1 and mem_ready=0.
REQ-029 stall = (memwrite!=00 and store aligned and full) or (memread and !empty).
REQ-030 While stall is high the MEM-stage inputs are held by the pipeline; the store is accepted on the first edge at which stall is low.
REQ-031 Loads are never serviced from buffer contents; a load proceeds only once the buffer is empty.
REQ-032 memwrite!=00 and memread high in the same cycle is illegal; behaviour is unspecified.

Reset
REQ-033 With reset high at a rising edge, pointers and count clear to 0 and misalign clears to 0.
REQ-034 After reset: empty=1, mem_we=0, mem_adr=0, mem_wdata=0, mem_be=0000, stall=0 (unless illegal inputs).
REQ-035 Reset mid-operation discards all buffered stores without writing them; stores presented during reset are dropped.
REQ-036 Storage array contents need not be reset.

Verification
REQ-037 sb: memwrite=11, dataadr=0x51, writedata=0x000000FF, mem_ready=1 -> next cycle mem_we=1, mem_adr=0x50, mem_be=0010, mem_wdata=0xFFFFFFFF; cycle after, empty=1.
REQ-038 sh: memwrite=10, dataadr=0x52, writedata=0x0000AAFF -> mem_adr=0x50, mem_be=1100, mem_wdata=0xAAFFAAFF.
REQ-039 Fill: mem_ready=0, five consecutive sw to 0x00,0x04,...,0x10 -> count reaches 4, stall=1 on fifth; raise mem_ready one cycle -> entry 0x00 written, fifth accepted next edge, drain order 0x04,0x08,0x0C,0x10.
REQ-040 Misaligned: sw at dataadr=0x52 -> misalign=1 next cycle only, count unchanged, mem_we stays 0, stall=0.
REQ-041 Load hazard: two stores buffered, mem_ready=0, memread=1 -> stall=1 until both popped; stall=0 in the cycle empty=1.
REQ-042 Reset mid-op: three entries buffered, reset pulsed one cycle -> next cycle count=0, mem_we=0, no further memory writes.
